// File: rtl/fixed_point_sign_arbiter.sv
// fixed_point_sign_arbiter
// Round-robin front end that lets NUM_REQ requesters share one sign-change
// unit. One transaction is in flight at a time. A watchdog converts a missing
// unit response into an error response so the owner is never left hanging.
module fixed_point_sign_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_VALUE,
  input  logic [NUM_REQ-1:0]       REQ_SIGN,
  output logic [NUM_REQ-1:0]       RESP_VALID,
  output logic [ID_W-1:0]          RESP_ID,
  output logic [WIDTH-1:0]         RESP_VALUE,
  output logic                     RESP_OVERFLOW,
  output logic                     RESP_ERROR,
  output logic                     BUSY,
  output logic                     CS_TARGET_SIGN,
  output logic [WIDTH-1:0]         CS_VALUE_IN,
  output logic                     CS_VALID_IN,
  input  logic [WIDTH-1:0]         CS_VALUE_OUT,
  input  logic                     CS_VALID_OUT,
  input  logic                     CS_OVERFLOW
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic [WIDTH-1:0] grant_value;
  logic             grant_sign;
  logic             accept;
  logic             wd_expired;

  logic [ID_W-1:0]  cap_id;
  logic [WIDTH-1:0] cap_value;
  logic             cap_sign;
  logic [CNT_W-1:0] wd_cnt;

  int unsigned      idx;

  // Cyclic search for the first valid requester after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!grant_found && REQ_VALID[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Mux out the granted requester's operand and target sign.
  always_comb begin
    grant_value = '0;
    grant_sign  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        grant_value = REQ_VALUE[i*WIDTH +: WIDTH];
        grant_sign  = REQ_SIGN[i];
      end
    end
  end

  assign wd_expired = (wd_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    REQ_READY   = '0;
    RESP_VALID  = '0;
    CS_VALID_IN = 1'b0;
    BUSY        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Ready is withheld during reset so nothing looks accepted.
        if (RSTN && grant_found) begin
          accept              = 1'b1;
          REQ_READY[grant_id] = 1'b1;
          state_nx            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        CS_VALID_IN = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: begin
        if (CS_VALID_OUT || wd_expired) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        RESP_VALID[RESP_ID] = 1'b1;
        state_nx            = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Request capture, round-robin pointer, watchdog and response registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr           <= ID_LAST;
      cap_id        <= '0;
      cap_value     <= '0;
      cap_sign      <= 1'b0;
      wd_cnt        <= '0;
      RESP_ID       <= '0;
      RESP_VALUE    <= '0;
      RESP_OVERFLOW <= 1'b0;
      RESP_ERROR    <= 1'b0;
    end else begin
      if (accept) begin
        cap_id    <= grant_id;
        cap_value <= grant_value;
        cap_sign  <= grant_sign;
        ptr       <= grant_id;
      end
      if (state == S_ISSUE) begin
        wd_cnt <= '0;
      end
      if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
        // A genuine result takes priority over a same-cycle timeout.
        if (CS_VALID_OUT) begin
          RESP_ID       <= cap_id;
          RESP_VALUE    <= CS_VALUE_OUT;
          RESP_OVERFLOW <= CS_OVERFLOW;
          RESP_ERROR    <= 1'b0;
        end else if (wd_expired) begin
          RESP_ID       <= cap_id;
          RESP_VALUE    <= '0;
          RESP_OVERFLOW <= 1'b0;
          RESP_ERROR    <= 1'b1;
        end
      end
    end
  end

  assign CS_VALUE_IN    = cap_value;
  assign CS_TARGET_SIGN = cap_sign;

endmodule

// File: doc/fixed_point_sign_arbiter.md
Name: fixed_point_sign_arbiter

Overview:
- Round-robin arbiter that shares one FIXED_POINT_CHANGE_SIGN instance among NUM_REQ requesters, so odd-symmetric function units can share a single sign-conversion datapath.
- Accepts one request at a time and drives the shared unit. It waits for the unit's variable latency: 1 cycle on sign match, 2 cycles on negation.
- Returns the result to the requester that issued it. A watchdog turns a lost response into an error response.

Parameters:
- WIDTH, 8, data width; must equal the shared unit's WIDTH.
- NUM_REQ, 4, number of requesters; must be ≥2.
- TIMEOUT, 8, max WAIT cycles before an error response; must be ≥3.
- ID_W, $clog2(NUM_REQ), requester index width (derived).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, synchronous, active-low.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester accept; one-hot or zero.
- REQ_VALUE  in  NUM_REQ*WIDTH  requester i uses slice [i*WIDTH +: WIDTH], signed.
- REQ_SIGN  in  NUM_REQ  target sign per requester (0 = positive, 1 = negative).
- RESP_VALID  out  NUM_REQ  one-cycle response pulse, one-hot, to the owning requester.
- RESP_ID  out  ID_W  index of the responding requester.
- RESP_VALUE  out  WIDTH  result, signed.
- RESP_OVERFLOW  out  1  overflow flag from the shared unit.
- RESP_ERROR  out  1  timeout indication.
- BUSY  out  1  high whenever the state is not IDLE.
- CS_TARGET_SIGN  out  1  to shared unit TARGET_SIGN.
- CS_VALUE_IN  out  WIDTH  to shared unit VALUE_IN.
- CS_VALID_IN  out  1  to shared unit VALID_IN.
- CS_VALUE_OUT  in  WIDTH  from shared unit VALUE_OUT.
- CS_VALID_OUT  in  1  from shared unit VALID_OUT.
- CS_OVERFLOW  in  1  from shared unit OVERFLOW.

Behaviour:
- Reset:
  - state IDLE; last-grant pointer = NUM_REQ-1, so index 0 wins first.
  - REQ_READY, RESP_VALID, CS_VALID_IN, BUSY, RESP_ERROR, RESP_OVERFLOW = 0.
  - RESP_VALUE, RESP_ID, CS_VALUE_IN, CS_TARGET_SIGN = 0.
  - Reset mid-operation aborts the transaction with no response. Any late CS_VALID_OUT after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with REQ_VALID[i], searching cyclically from pointer+1.
  - REQ_READY[grant] = 1 combinationally in IDLE only. No requests → REQ_READY = 0.
  - On REQ_VALID & REQ_READY: capture value, sign and id; update pointer to grant; go to ISSUE.
- ISSUE:
  - CS_VALID_IN = 1 for exactly this cycle; CS_VALUE_IN and CS_TARGET_SIGN come from the captured registers.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - CS_VALID_OUT = 1: capture CS_VALUE_OUT and CS_OVERFLOW, set RESP_ERROR = 0, go to RESP.
  - Counter reaches TIMEOUT-1 without CS_VALID_OUT: set RESP_VALUE = 0, RESP_OVERFLOW = 0, RESP_ERROR = 1, go to RESP.
  - If CS_VALID_OUT coincides with the timeout cycle, the valid result wins.
- RESP:
  - RESP_VALID[id] = 1 for one cycle, with RESP_ID/RESP_VALUE/RESP_OVERFLOW/RESP_ERROR valid. No backpressure.
  - Go to IDLE. Response fields hold their values until the next RESP.
- Input hold rules:
  - CS_VALID_OUT outside WAIT is ignored.
  - CS_VALUE_IN/CS_TARGET_SIGN hold until the next accept.
- Latency:
  - Accept at cycle 0 → CS_VALID_IN at cycle 1.
  - Sign-match response at cycle 3; negation response at cycle 4.
  - Next accept is possible in the cycle after RESP.
- Fairness: a requester held valid is served within NUM_REQ transactions. A requester that drops REQ_VALID before its handshake loses its turn, with no penalty.
- Arithmetic: no computation in this block. Values pass through bit-exact and signed.

Test Plan:
- Single request: requester 2, REQ_VALUE = 8'sd5, REQ_SIGN = 1; unit negates → RESP_VALID = 4'b0100, RESP_ID = 2, RESP_VALUE = -5, RESP_ERROR = 0, response at cycle 4 after accept.
- Sign match: requester 0, value -3, REQ_SIGN = 1 → RESP_VALUE = -3, response at cycle 3; CS_VALID_IN pulses exactly once.
- Round-robin: all 4 requesters held valid for 8 transactions → grant order 0,1,2,3,0,1,2,3; REQ_READY always one-hot.
- Overflow: requester 1, value -128 (WIDTH = 8), REQ_SIGN = 0 → RESP_OVERFLOW mirrors CS_OVERFLOW; RESP_VALUE equals CS_VALUE_OUT bit-exact.
- Timeout: unit model stalls CS_VALID_OUT, TIMEOUT = 8 → RESP_ERROR = 1, RESP_VALUE = 0, RESP_VALID to the owner; the next request is then served normally.
- Reset in WAIT, followed by a late CS_VALID_OUT → no RESP_VALID pulse, BUSY = 0, next grant goes to index 0.
